sequential_multiply_unit: RTL and testbench
===========================================

SEQUENTIAL_MULTIPLY_UNIT -- requirements
Module: sequential_multiply_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: product width, equal to the width of the downstream accumulate input.
REQ-002 The block SHALL have parameter VAR_WIDTH, default 8: operand width; DATA_WIDTH SHALL equal 2*VAR_WIDTH.
REQ-003 Port clock: input, 1 bit; rising-edge clock.
REQ-004 Port reset: input, 1 bit; asynchronous, active-low reset.
REQ-005 Port clear: input, 1 bit; synchronous abort and zeroing.
REQ-006 Port start: input, 1 bit; request to begin a multiply.
REQ-007 Port sign_en: input, 1 bit; 1 = operands are two's complement, 0 = unsigned; sampled with start.
REQ-008 Port a: input, VAR_WIDTH bits; multiplicand.
REQ-009 Port b: input, VAR_WIDTH bits; multiplier.
REQ-010 Port busy: output, 1 bit; high whenever the state is not IDLE.
REQ-011 Port listo: output, 1 bit; one-cycle pulse marking result valid; feeds the accumulate stage's listo input.
REQ-012 Port result: output, DATA_WIDTH bits; product; feeds the accumulate stage's result input.

Function
REQ-013 The FSM SHALL have states IDLE, MULT and DONE.
REQ-014 IDLE->MULT: start=1 and clear=0; a, b and sign_en are registered on that edge.
REQ-015 When sign_en=1, each operand SHALL be converted to magnitude, and neg_flag SHALL be set to sign(a) XOR sign(b); a magnitude of -2^(VAR_WIDTH-1) SHALL be handled as 2^(VAR_WIDTH-1) without overflow.
REQ-016 MULT SHALL perform shift-add: each cycle, if the multiplier LSB=1, the partial product (DATA_WIDTH bits) SHALL add the shifted multiplicand; the multiplicand SHALL then shift left and the multiplier right.
REQ-017 MULT SHALL last exactly VAR_WIDTH cycles, counted by an iteration counter of width $clog2(VAR_WIDTH+1).
REQ-018 MULT->DONE: after the last iteration; on that edge, result SHALL be loaded with the partial product, two's-complement negated if neg_flag=1.
REQ-019 DONE SHALL last one cycle, with listo=1; then DONE->IDLE unconditionally.
REQ-020 Latency: start high in cycle 0 SHALL give busy=1 in cycles 1..VAR_WIDTH+1, listo=1 in cycle VAR_WIDTH+1 only, and busy=0 in cycle VAR_WIDTH+2.
REQ-021 result SHALL hold its value from DONE until the next DONE, clear or reset.
REQ-022 start while busy=1 (including in DONE) SHALL be ignored and not queued; maximum throughput is one product per VAR_WIDTH+2 cycles.
REQ-023 clear=1 in any state SHALL force IDLE, result=0, listo=0 and zero the internal registers on the next edge; clear SHALL take priority over start.
REQ-024 Arithmetic SHALL be exact for all operand pairs; an unsigned product SHALL never wrap, and the signed range SHALL be -2^(2*VAR_WIDTH-2)+2^(VAR_WIDTH-1) .. 2^(2*VAR_WIDTH-2).
REQ-025 A zero operand SHALL still take the full latency and yield result=0, listo=1, with no negative zero.
REQ-026 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, result=0, listo=0, busy=0 and zero all internal registers, including mid-multiply.
REQ-028 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-029 DATA_WIDTH and VAR_WIDTH defaults and the FSM state enum type SHALL live in shared package matrix_pkg, which the accumulate stage also uses.
REQ-030 The block SHALL be a single module with no sub-module; sign conversion SHALL be done inline.

Verification
REQ-031 Unsigned a=3, b=5, start at cycle 0 -> listo=1 at cycle 9 only, result=0x000F, busy=0 at cycle 10.
REQ-032 Unsigned a=255, b=255 -> result=0xFE01; signed a=0x80, b=0x80 -> result=0x4000.
REQ-033 Signed a=0xFD (-3), b=0x07 -> result=0xFFEB (-21); signed a=0x00, b=0x80 -> result=0x0000.
REQ-034 Start a=9, b=9; clear at cycle 4 -> no listo, result=0, busy=0 at cycle 5; a new start at cycle 5 completes normally.
REQ-035 Start a=2, b=3, then start a=7, b=7 at cycles 3 and 9 -> both ignored, single listo at cycle 9 with result=6.
REQ-036 reset low at cycle 5 of a multiply -> outputs zero immediately; start after release -> correct product 9 cycles later.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: default widths and the
// multiply/accumulate FSM state type.
package matrix_pkg;

  localparam int unsigned DEFAULT_VAR_WIDTH  = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 2 * DEFAULT_VAR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sequential_multiply_unit.sv
// Shift-add multiplier: one operand bit per cycle, optional two's-complement
// operands handled as sign-magnitude, result held until the next product.
module sequential_multiply_unit
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned VAR_WIDTH  = DEFAULT_VAR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  sign_en,
  input  logic [VAR_WIDTH-1:0]  a,
  input  logic [VAR_WIDTH-1:0]  b,
  output logic                  busy,
  output logic                  listo,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(VAR_WIDTH + 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] partial;
  logic [VAR_WIDTH-1:0]  mplier;
  logic [CNT_W-1:0]      iter;
  logic                  neg_flag;

  logic [VAR_WIDTH-1:0]  a_mag;
  logic [VAR_WIDTH-1:0]  b_mag;
  logic [DATA_WIDTH-1:0] partial_next;
  logic [DATA_WIDTH-1:0] product_final;

  // Magnitudes stay unsigned, so the most negative operand maps to 2^(W-1) cleanly.
  always_comb begin
    a_mag         = a;
    b_mag         = b;
    partial_next  = partial;
    product_final = '0;
    if (sign_en && a[VAR_WIDTH-1]) a_mag = ~a + VAR_WIDTH'(1);
    if (sign_en && b[VAR_WIDTH-1]) b_mag = ~b + VAR_WIDTH'(1);
    if (mplier[0]) partial_next = partial + mcand;
    product_final = neg_flag ? (~partial_next + DATA_WIDTH'(1)) : partial_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      listo    <= 1'b0;
      result   <= '0;
      mcand    <= '0;
      partial  <= '0;
      mplier   <= '0;
      iter     <= '0;
      neg_flag <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      busy     <= 1'b0;
      listo    <= 1'b0;
      result   <= '0;
      mcand    <= '0;
      partial  <= '0;
      mplier   <= '0;
      iter     <= '0;
      neg_flag <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= MULT;
            busy     <= 1'b1;
            mcand    <= DATA_WIDTH'(a_mag);
            mplier   <= b_mag;
            neg_flag <= sign_en & (a[VAR_WIDTH-1] ^ b[VAR_WIDTH-1]);
            partial  <= '0;
            iter     <= '0;
          end
        end
        MULT: begin
          partial <= partial_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          iter    <= iter + CNT_W'(1);
          if (iter == CNT_W'(VAR_WIDTH - 1)) begin
            state  <= DONE;
            result <= product_final;
            listo  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_multiply_unit.sv
// Directed bench for sequential_multiply_unit with a cycle-count reference model.
module tb_sequential_multiply_unit;

  localparam int unsigned VW = 8;
  localparam int unsigned DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          sign_en = 1'b0;
  logic [VW-1:0] a = '0;
  logic [VW-1:0] b = '0;
  logic          busy;
  logic          listo;
  logic [DW-1:0] result;

  sequential_multiply_unit #(.DATA_WIDTH(DW), .VAR_WIDTH(VW)) dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start),
    .sign_en(sign_en), .a(a), .b(b),
    .busy(busy), .listo(listo), .result(result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] exp_prod(input logic [VW-1:0] x, input logic [VW-1:0] y,
                                             input logic s);
    int p;
    if (s) p = int'($signed(x)) * int'($signed(y));
    else   p = int'(x) * int'(y);
    return DW'(p);
  endfunction

  // Reference: a product occupies VW+1 busy cycles and appears on the last one.
  int            m_left;
  logic          m_listo;
  logic [DW-1:0] m_result;
  logic [DW-1:0] m_pending;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_left <= 0; m_listo <= 1'b0; m_result <= '0; m_pending <= '0;
    end else if (clear) begin
      m_left <= 0; m_listo <= 1'b0; m_result <= '0;
    end else begin
      m_listo <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left    <= VW + 1;
          m_pending <= exp_prod(a, b, sign_en);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_result <= m_pending;
          m_listo  <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("model busy",   32'(busy),   32'(m_left != 0));
      chk("model listo",  32'(listo),  32'(m_listo));
      chk("model result", 32'(result), 32'(m_result));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mul(input logic [VW-1:0] ta, input logic [VW-1:0] tb_b, input logic ts,
                     input logic [DW-1:0] exp, input string name);
    int t0;
    int waited;
    a = ta; b = tb_b; sign_en = ts; start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    waited = 0;
    while (!listo && waited < 20) begin
      step();
      waited++;
    end
    if (!listo) begin
      chk({name, " listo timeout"}, 32'(listo), 32'd1);
    end else begin
      chk({name, " latency"}, 32'(cyc - t0), 32'(VW + 1));
      chk({name, " result"}, 32'(result), 32'(exp));
    end
    step();
    chk({name, " busy after"}, 32'(busy), 32'd0);
    chk({name, " listo after"}, 32'(listo), 32'd0);
  endtask

  initial begin
    chk("pin model s FD*07", 32'(exp_prod(8'hFD, 8'h07, 1'b1)), 32'h0000_FFEB);
    chk("pin model s 80*80", 32'(exp_prod(8'h80, 8'h80, 1'b1)), 32'h0000_4000);
    chk("pin model u FF*FF", 32'(exp_prod(8'hFF, 8'hFF, 1'b0)), 32'h0000_FE01);

    repeat (2) @(posedge clock);
    #1;
    chk("reset busy",   32'(busy),   32'd0);
    chk("reset listo",  32'(listo),  32'd0);
    chk("reset result", 32'(result), 32'd0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Start immediately after reset release: accepted on the first edge.
    mul(8'd3,   8'd5,   1'b0, 16'h000F, "u 3*5");
    mul(8'hFF,  8'hFF,  1'b0, 16'hFE01, "u FF*FF");
    mul(8'h80,  8'h80,  1'b1, 16'h4000, "s 80*80");
    mul(8'hFD,  8'h07,  1'b1, 16'hFFEB, "s FD*07");
    mul(8'h00,  8'h80,  1'b1, 16'h0000, "s 00*80");
    mul(8'h80,  8'h7F,  1'b1, 16'hC080, "s 80*7F");
    mul(8'h80,  8'h01,  1'b1, 16'hFF80, "s 80*01");
    mul(8'h7F,  8'h7F,  1'b1, 16'h3F01, "s 7F*7F");
    mul(8'h80,  8'h00,  1'b1, 16'h0000, "s 80*00");
    mul(8'h00,  8'h37,  1'b0, 16'h0000, "u 00*37");

    // Clear mid-multiply wipes the previous result and aborts.
    a = 8'd9; b = 8'd9; sign_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear busy",   32'(busy),   32'd0);
    chk("clear listo",  32'(listo),  32'd0);
    chk("clear result", 32'(result), 32'd0);
    mul(8'd4, 8'd6, 1'b0, 16'd24, "after clear");

    // Starts during MULT and during DONE are dropped.
    a = 8'd2; b = 8'd3; sign_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    a = 8'd7; b = 8'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    a = 8'd7; b = 8'd7; start = 1'b1;
    chk("ignore listo c9",  32'(listo),  32'd1);
    chk("ignore result c9", 32'(result), 32'd6);
    step();
    start = 1'b0;
    chk("ignore busy c10",  32'(busy),  32'd0);
    chk("ignore listo c10", 32'(listo), 32'd0);
    step();
    chk("ignore busy c11",  32'(busy),   32'd0);
    chk("ignore result c11", 32'(result), 32'd6);

    // Asynchronous reset in the middle of a multiply.
    a = 8'd12; b = 8'd13; sign_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    #1;
    chk("async rst busy",   32'(busy),   32'd0);
    chk("async rst listo",  32'(listo),  32'd0);
    chk("async rst result", 32'(result), 32'd0);
    #2;
    reset = 1'b1;
    mul(8'd3, 8'd3, 1'b0, 16'd9, "post reset");

    repeat (2) step();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
